// File: rtl/cube_sum_acc_if.sv
// Stream bundle for cube_sum_acc: cube samples in,
// saturated frame totals out, both valid/ready.
interface cube_sum_acc_if #(
  parameter int SUM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       cube_in;
  logic             sum_valid;
  logic             sum_ready;
  logic [SUM_W-1:0] sum_out;
  logic             ovf;

  modport master (
    output in_valid,
    output cube_in,
    output sum_ready,
    input  in_ready,
    input  sum_valid,
    input  sum_out,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  cube_in,
    input  sum_ready,
    output in_ready,
    output sum_valid,
    output sum_out,
    output ovf
  );
endinterface

// File: rtl/cube_sum_acc.sv
// Frame accumulator: sums FRAME_LEN cube samples with
// saturation and presents each total until consumed.
module cube_sum_acc #(
  parameter int FRAME_LEN = 4,
  parameter int SUM_W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  cube_sum_acc_if.slave bus
);

  localparam int CNT_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_d;
  logic             sat_q;
  logic             sat_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             in_ready;
  logic             sum_valid;
  logic             take;
  logic             is_last;
  logic             take_last;
  logic             take_mid;
  logic [SUM_W:0]   add_full;
  logic             carry;
  logic [SUM_W-1:0] add_sat;

  assign take      = bus.in_valid & in_ready;
  assign is_last   = (cnt_q == LAST);
  assign take_last = take & is_last & ~clear;
  assign take_mid  = take & ~is_last & ~clear;

  // One extra bit catches the wrap so it can clamp.
  assign add_full = {1'b0, acc_q}
                  + {{(SUM_W-4){1'b0}}, bus.cube_in};
  assign carry    = add_full[SUM_W];
  assign add_sat  = carry ? {SUM_W{1'b1}}
                          : add_full[SUM_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM: if (take_last) state_d = HOLD;
        HOLD:  if (bus.sum_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    case (state_q)
      ACCUM: in_ready  = 1'b1;
      HOLD:  sum_valid = 1'b1;
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    unique case (1'b1)
      clear: begin
        acc_d = '0;
        sat_d = 1'b0;
        cnt_d = '0;
        sum_d = '0;
        ovf_d = 1'b0;
      end
      take_last: begin
        sum_d = add_sat;
        ovf_d = sat_q | carry;
        acc_d = '0;
        sat_d = 1'b0;
        cnt_d = '0;
      end
      take_mid: begin
        acc_d = add_sat;
        sat_d = sat_q | carry;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sum_valid = sum_valid;
  assign bus.sum_out   = sum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cube_sum_acc.sv
// Bench for cube_sum_acc: directed scenarios plus random
// traffic on three parameterisations against a frame model.
module tb_cube_sum_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clr_a;
  logic clr_b;
  logic clr_c;

  cube_sum_acc_if #(.SUM_W(8)) a_if ();
  cube_sum_acc_if #(.SUM_W(6)) b_if ();
  cube_sum_acc_if #(.SUM_W(8)) c_if ();

  cube_sum_acc #(.FRAME_LEN(4), .SUM_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clr_a), .bus(a_if)
  );
  cube_sum_acc #(.FRAME_LEN(4), .SUM_W(6)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clr_b), .bus(b_if)
  );
  cube_sum_acc #(.FRAME_LEN(1), .SUM_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clr_c), .bus(c_if)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Frame-level model: running true total, clamped on emit.
  int fl [3] = '{4, 4, 1};
  int sw [3] = '{8, 6, 8};
  bit m_hold [3];
  int m_tot  [3];
  int m_n    [3];
  int m_sum  [3];
  bit m_ovf  [3];

  function automatic void model_edge(
    int k, bit rn, bit cl, bit v, int cube, bit rdy
  );
    int mx;
    mx = (1 << sw[k]) - 1;
    if (!rn || cl) begin
      m_hold[k] = 1'b0;
      m_tot[k]  = 0;
      m_n[k]    = 0;
      m_sum[k]  = 0;
      m_ovf[k]  = 1'b0;
    end else if (m_hold[k]) begin
      if (rdy) m_hold[k] = 1'b0;
    end else if (v) begin
      m_tot[k] = m_tot[k] + cube;
      m_n[k]   = m_n[k] + 1;
      if (m_n[k] == fl[k]) begin
        m_sum[k]  = (m_tot[k] > mx) ? mx : m_tot[k];
        m_ovf[k]  = (m_tot[k] > mx);
        m_hold[k] = 1'b1;
        m_tot[k]  = 0;
        m_n[k]    = 0;
      end
    end
  endfunction

  task automatic idle_all();
    a_if.in_valid = 0; a_if.cube_in = 0; a_if.sum_ready = 0;
    b_if.in_valid = 0; b_if.cube_in = 0; b_if.sum_ready = 0;
    c_if.in_valid = 0; c_if.cube_in = 0; c_if.sum_ready = 0;
    clr_a = 0; clr_b = 0; clr_c = 0;
  endtask

  task automatic cycle();
    bit rn, ca, cb, cc, va, vb, vc, ra, rb, rc;
    int da, db, dc;
    rn = rst_n;
    ca = clr_a; va = a_if.in_valid; da = a_if.cube_in;
    ra = a_if.sum_ready;
    cb = clr_b; vb = b_if.in_valid; db = b_if.cube_in;
    rb = b_if.sum_ready;
    cc = clr_c; vc = c_if.in_valid; dc = c_if.cube_in;
    rc = c_if.sum_ready;
    @(posedge clk);
    model_edge(0, rn, ca, va, da, ra);
    model_edge(1, rn, cb, vb, db, rb);
    model_edge(2, rn, cc, vc, dc, rc);
    #1;
  endtask

  task automatic feed_a(input int d);
    a_if.in_valid = 1; a_if.cube_in = 5'(d);
    cycle();
    a_if.in_valid = 0;
  endtask

  task automatic feed_b(input int d);
    b_if.in_valid = 1; b_if.cube_in = 5'(d);
    cycle();
    b_if.in_valid = 0;
  endtask

  task automatic release_a();
    a_if.sum_ready = 1;
    cycle();
    a_if.sum_ready = 0;
  endtask

  task automatic test_reset();
    logic [10:0] ga, gc;
    logic [8:0]  gb;
    idle_all();
    rst_n = 0;
    cycle(); cycle();
    rst_n = 1;
    ga = {a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out};
    gb = {b_if.in_ready, b_if.sum_valid, b_if.ovf, b_if.sum_out};
    gc = {c_if.in_ready, c_if.sum_valid, c_if.ovf, c_if.sum_out};
    n_tot++;
    if (ga !== 11'h400) $display("FAIL reset_a: got %h want 400", ga);
    else n_pass++;
    n_tot++;
    if (gb !== 9'h100) $display("FAIL reset_b: got %h want 100", gb);
    else n_pass++;
    n_tot++;
    if (gc !== 11'h400) $display("FAIL reset_c: got %h want 400", gc);
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    int v [4] = '{1, 8, 27, 0};
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (a_if.in_ready !== 1'b1)
        $display("FAIL basic_rdy%0d: got %b want 1", i, a_if.in_ready);
      else n_pass++;
      feed_a(v[i]);
    end
    n_tot++;
    if (a_if.sum_out !== 8'd36)
      $display("FAIL basic_sum: got %0d want 36", a_if.sum_out);
    else n_pass++;
    n_tot++;
    if ({a_if.in_ready, a_if.sum_valid, a_if.ovf} !== 3'b010)
      $display("FAIL basic_flags: got %b want 010",
               {a_if.in_ready, a_if.sum_valid, a_if.ovf});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      a_if.in_valid = 1; a_if.cube_in = 5'd27; a_if.sum_ready = 0;
      cycle();
      n_tot++;
      if ({a_if.in_ready, a_if.sum_valid, a_if.sum_out} !== {2'b01, 8'd36})
        $display("FAIL bp_hold%0d: got %b/%b/%0d want 0/1/36", i,
                 a_if.in_ready, a_if.sum_valid, a_if.sum_out);
      else n_pass++;
    end
    a_if.in_valid = 0;
    release_a();
    n_tot++;
    if ({a_if.in_ready, a_if.sum_valid} !== 2'b10)
      $display("FAIL bp_release: got %b want 10",
               {a_if.in_ready, a_if.sum_valid});
    else n_pass++;
    for (int i = 0; i < 4; i++) feed_a(27);
    n_tot++;
    if ({a_if.sum_valid, a_if.ovf, a_if.sum_out} !== {2'b10, 8'd108})
      $display("FAIL bp_next: got %b/%b/%0d want 1/0/108",
               a_if.sum_valid, a_if.ovf, a_if.sum_out);
    else n_pass++;
    release_a();
  endtask

  task automatic test_saturation();
    int v [4] = '{27, 27, 27, 1};
    for (int i = 0; i < 4; i++) feed_b(v[i]);
    n_tot++;
    if ({b_if.sum_valid, b_if.ovf, b_if.sum_out} !== {2'b11, 6'd63})
      $display("FAIL sat_frame: got %b/%b/%0d want 1/1/63",
               b_if.sum_valid, b_if.ovf, b_if.sum_out);
    else n_pass++;
    b_if.sum_ready = 1; cycle(); b_if.sum_ready = 0;
    for (int i = 0; i < 4; i++) feed_b(1);
    n_tot++;
    if ({b_if.sum_valid, b_if.ovf, b_if.sum_out} !== {2'b10, 6'd4})
      $display("FAIL sat_after: got %b/%b/%0d want 1/0/4",
               b_if.sum_valid, b_if.ovf, b_if.sum_out);
    else n_pass++;
    b_if.sum_ready = 1; cycle(); b_if.sum_ready = 0;
  endtask

  task automatic test_gaps();
    bit vp [7] = '{1, 0, 0, 1, 1, 0, 1};
    int dp [7] = '{8, 0, 0, 8, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      a_if.in_valid = vp[i];
      a_if.cube_in  = vp[i] ? 5'(dp[i]) : 5'($urandom_range(0, 31));
      cycle();
      if (i < 6) begin
        n_tot++;
        if (a_if.sum_valid !== 1'b0)
          $display("FAIL gap_early%0d: got %b want 0", i, a_if.sum_valid);
        else n_pass++;
      end
    end
    a_if.in_valid = 0;
    n_tot++;
    if ({a_if.sum_valid, a_if.sum_out} !== {1'b1, 8'd17})
      $display("FAIL gap_sum: got %b/%0d want 1/17",
               a_if.sum_valid, a_if.sum_out);
    else n_pass++;
    release_a();
    c_if.in_valid = 1; c_if.cube_in = 5'd27;
    cycle();
    c_if.in_valid = 0;
    n_tot++;
    if ({c_if.in_ready, c_if.sum_valid, c_if.ovf, c_if.sum_out}
        !== {3'b010, 8'd27})
      $display("FAIL len1_sum: got %b/%b/%0d want 0/1/27",
               c_if.in_ready, c_if.sum_valid, c_if.sum_out);
    else n_pass++;
    c_if.sum_ready = 1; cycle(); c_if.sum_ready = 0;
    n_tot++;
    if (c_if.in_ready !== 1'b1)
      $display("FAIL len1_rel: got %b want 1", c_if.in_ready);
    else n_pass++;
  endtask

  task automatic test_clear();
    feed_a(27);
    feed_a(27);
    clr_a = 1; a_if.in_valid = 1; a_if.cube_in = 5'd8;
    cycle();
    clr_a = 0; a_if.in_valid = 0;
    n_tot++;
    if ({a_if.in_ready, a_if.sum_valid, a_if.sum_out} !== {2'b10, 8'd0})
      $display("FAIL clr_mid: got %b/%b/%0d want 1/0/0",
               a_if.in_ready, a_if.sum_valid, a_if.sum_out);
    else n_pass++;
    for (int i = 0; i < 4; i++) feed_a(1);
    n_tot++;
    if ({a_if.sum_valid, a_if.sum_out} !== {1'b1, 8'd4})
      $display("FAIL clr_next: got %b/%0d want 1/4",
               a_if.sum_valid, a_if.sum_out);
    else n_pass++;
    clr_a = 1; a_if.sum_ready = 0;
    cycle();
    clr_a = 0;
    n_tot++;
    if ({a_if.in_ready, a_if.sum_valid, a_if.sum_out} !== {2'b10, 8'd0})
      $display("FAIL clr_hold: got %b/%b/%0d want 1/0/0",
               a_if.in_ready, a_if.sum_valid, a_if.sum_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int v [4] = '{1, 8, 27, 0};
    for (int i = 0; i < 4; i++) feed_a(1);
    n_tot++;
    if (a_if.sum_valid !== 1'b1)
      $display("FAIL rmid_hold: got %b want 1", a_if.sum_valid);
    else n_pass++;
    rst_n = 0; cycle(); rst_n = 1;
    n_tot++;
    if ({a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out}
        !== 11'h400)
      $display("FAIL rmid_inhold: got %h want 400",
               {a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out});
    else n_pass++;
    feed_a(8);
    feed_a(8);
    rst_n = 0; cycle(); rst_n = 1;
    n_tot++;
    if ({a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out}
        !== 11'h400)
      $display("FAIL rmid_frame: got %h want 400",
               {a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out});
    else n_pass++;
    for (int i = 0; i < 4; i++) feed_a(v[i]);
    n_tot++;
    if ({a_if.sum_valid, a_if.sum_out} !== {1'b1, 8'd36})
      $display("FAIL rmid_fresh: got %b/%0d want 1/36",
               a_if.sum_valid, a_if.sum_out);
    else n_pass++;
    release_a();
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, exp;
    a_if.in_valid = 1; a_if.sum_ready = 1;
    for (int i = 0; i < 40; i++) begin
      a_if.cube_in = 5'($urandom_range(0, 31));
      cycle();
      got = {a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out};
      exp = {~m_hold[0], m_hold[0], m_ovf[0], m_sum[0][7:0]};
      n_tot++;
      if (got !== exp)
        $display("FAIL b2b%0d: got %h want %h", i, got, exp);
      else n_pass++;
    end
    idle_all();
    cycle();
  endtask

  task automatic test_random();
    logic [10:0] ga, ea, gc, ec;
    logic [8:0]  gb, eb;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 150) != 0);
      clr_a = ($urandom_range(0, 40) == 0);
      clr_b = ($urandom_range(0, 40) == 0);
      clr_c = ($urandom_range(0, 40) == 0);
      a_if.in_valid  = ($urandom_range(0, 3) != 0);
      a_if.cube_in   = 5'($urandom_range(0, 31));
      a_if.sum_ready = ($urandom_range(0, 2) == 0);
      b_if.in_valid  = ($urandom_range(0, 3) != 0);
      b_if.cube_in   = 5'($urandom_range(0, 31));
      b_if.sum_ready = ($urandom_range(0, 2) == 0);
      c_if.in_valid  = ($urandom_range(0, 1) != 0);
      c_if.cube_in   = 5'($urandom_range(0, 31));
      c_if.sum_ready = ($urandom_range(0, 2) == 0);
      cycle();
      ga = {a_if.in_ready, a_if.sum_valid, a_if.ovf, a_if.sum_out};
      ea = {~m_hold[0], m_hold[0], m_ovf[0], m_sum[0][7:0]};
      gb = {b_if.in_ready, b_if.sum_valid, b_if.ovf, b_if.sum_out};
      eb = {~m_hold[1], m_hold[1], m_ovf[1], m_sum[1][5:0]};
      gc = {c_if.in_ready, c_if.sum_valid, c_if.ovf, c_if.sum_out};
      ec = {~m_hold[2], m_hold[2], m_ovf[2], m_sum[2][7:0]};
      n_tot++;
      if (ga !== ea) $display("FAIL rand_a%0d: got %h want %h", i, ga, ea);
      else n_pass++;
      n_tot++;
      if (gb !== eb) $display("FAIL rand_b%0d: got %h want %h", i, gb, eb);
      else n_pass++;
      n_tot++;
      if (gc !== ec) $display("FAIL rand_c%0d: got %h want %h", i, gc, ec);
      else n_pass++;
    end
    rst_n = 1;
    idle_all();
  endtask

  initial begin
    rst_n = 0;
    idle_all();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_saturation();
    test_gaps();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cube_sum_acc.md
# cube_sum_acc

Frame accumulator sitting directly downstream of the 2-bit cube stage. It consumes a stream of 5-bit cube values over a valid/ready handshake and sums `FRAME_LEN` consecutive samples. It presents each frame total, with saturation and an overflow flag, on a second valid/ready output port. Together these turn a per-sample combinational cube into a framed sum-of-cubes result for the downstream consumer.

## Interface
Parameters:
- `FRAME_LEN`, default 4: samples per frame; legal values are ≥1.
- `SUM_W`, default 8: width of the sum. It must be ≥5.

Ports:
- `clk`, input, 1 bit: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1 bit: reset, synchronous and active-low.
- `clear`, input, 1 bit: synchronous frame abort, active-high.
- `in_valid`, input, 1 bit: `cube_in` is valid.
- `in_ready`, output, 1 bit: the block accepts `cube_in`.
- `cube_in`, input, 5 bits: cube value from the upstream stage, unsigned. Any 5-bit value is summed as-is.
- `sum_valid`, output, 1 bit: `sum_out` and `ovf` are valid.
- `sum_ready`, input, 1 bit: the downstream consumer accepts the sum.
- `sum_out`, output, `SUM_W` bits: the saturated frame total.
- `ovf`, output, 1 bit: the frame total exceeded 2^SUM_W−1.

## Operation
- **States:**
  - ACCUM: `in_ready`=1, `sum_valid`=0.
  - HOLD: `in_ready`=0, `sum_valid`=1.
- **Internal registers:**
  - `acc`: `SUM_W` bits.
  - `sat`: sticky flag, 1 bit.
  - `cnt`: counts 0..`FRAME_LEN`−1, width clog2(`FRAME_LEN`), minimum 1.
- **Accept:** a sample is accepted when `in_valid && in_ready` at a clock edge.
- **ACCUM, accepted sample, `cnt` < `FRAME_LEN`−1:**
  - `acc` ← sat(`acc`+`cube_in`).
  - `sat` ← `sat` | carry.
  - `cnt` ← `cnt`+1.
- **ACCUM, accepted sample, `cnt` = `FRAME_LEN`−1:**
  - `sum_out` ← sat(`acc`+`cube_in`).
  - `ovf` ← `sat` | carry.
  - `acc`, `sat` and `cnt` ← 0.
  - State → HOLD.
- **Saturation arithmetic:** the add is done at `SUM_W`+1 bits. If bit `SUM_W` is set, the result clamps to all-ones and carry=1. Once `acc` is saturated it stays saturated for the rest of the frame.
- **HOLD:** `sum_out` and `ovf` hold stable until `sum_ready`=1. On that edge the state → ACCUM.
- **`FRAME_LEN`=1:** every accepted sample goes directly to HOLD.
- **Priority at an edge:** `rst_n`=0 first, then `clear`=1, then normal operation.
- **`clear`=1 (with `rst_n`=1):**
  - State → ACCUM; `acc`, `sat` and `cnt` ← 0.
  - `sum_out` and `ovf` ← 0.
  - Any sample presented on the same edge is discarded.
  - A pending HOLD result is dropped without being delivered.
- **Reset values (`rst_n`=0 at an edge):** state ACCUM, `acc`=0, `sat`=0, `cnt`=0, `sum_out`=0, `ovf`=0. Outputs read `in_ready`=1, `sum_valid`=0. This applies mid-frame and mid-HOLD alike.
- **Output derivation:** `in_ready` and `sum_valid` are decoded directly from the state register. Neither depends combinationally on `in_valid`, `sum_ready` or `clear`.

## Timing
- **Result latency:** `sum_valid` rises on the edge that accepts the last sample of a frame. It is visible in the following cycle.
- **Release latency:** when `sum_ready`=1 at an edge in HOLD, `sum_valid` falls and `in_ready` rises after that edge. There is no same-cycle bypass.
- **Throughput:** at most one sample per cycle. A frame occupies at least `FRAME_LEN`+1 cycles: `FRAME_LEN` accept cycles plus at least one HOLD cycle.
- **Input stalls:** `in_valid`=0 cycles in ACCUM leave every register unchanged.
- **Output stalls:** `sum_ready` held low keeps HOLD indefinitely, with `sum_out` and `ovf` stable.
- **`clear` / `rst_n` effect:** both take effect at the edge where they are sampled. Outputs reflect the reset values in the next cycle.

## Test plan
- **Basic frame:** defaults (`FRAME_LEN`=4, `SUM_W`=8), `in_valid`=1 on consecutive cycles with `cube_in`=1, 8, 27, 0 → the cycle after the 4th accept shows `sum_valid`=1, `sum_out`=36, `ovf`=0, `in_ready`=0.
- **Output backpressure:** after the basic frame, hold `sum_ready`=0 for 3 cycles, then 1 → `sum_out`=36 stable for all 3 cycles, and an `in_valid`=1 `cube_in`=27 presented during them is not accepted. `in_ready`=1 only in the cycle after the `sum_ready` edge. The next frame of 27,27,27,27 gives 108.
- **Saturation:** `SUM_W`=6, `FRAME_LEN`=4, inputs 27, 27, 27, 1 → `sum_out`=63, `ovf`=1. The following frame of 1,1,1,1 gives `sum_out`=4, `ovf`=0.
- **Input gaps and `FRAME_LEN`=1:** defaults with `in_valid` pattern 1,0,0,1,1,0,1 carrying 8,x,x,8,1,x,0 → `sum_out`=17, emitted only after the 4th valid. Separately, with `FRAME_LEN`=1, `cube_in`=27 → `sum_out`=27 the next cycle.
- **Clear mid-frame:** accept 27, 27, then `clear`=1 together with `in_valid`=1 `cube_in`=8 → the 8 is discarded. A subsequent 1,1,1,1 yields `sum_out`=4. `clear` asserted in HOLD → `sum_valid`=0 and `sum_out`=0 next cycle.
- **Reset mid-operation:** `rst_n`=0 for one edge while in HOLD, then again after 2 accepts of a frame → each time the next cycle shows `in_ready`=1, `sum_valid`=0, `sum_out`=0, `ovf`=0. A fresh frame of 1,8,27,0 then gives 36.
